// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures period and high time of a synchronous divided clock and flags mismatches.
module clk_div_monitor #(
  parameter int LOCK_CNT = 4,
  parameter int CNT_W = 11
) (
  input  logic             i_clk,
  input  logic             i_rst_b,
  input  logic             i_div_clk,
  input  logic             i_en,
  input  logic [9:0]       i_exp_div_num,
  input  logic             i_err_clr,
  output logic [CNT_W-1:0] o_period,
  output logic [CNT_W-1:0] o_high_cnt,
  output logic             o_valid,
  output logic             o_locked,
  output logic             o_err_period,
  output logic             o_err_duty,
  output logic             o_err_timeout
);
  typedef enum logic [1:0] {IDLE, ARM, MEASURE} state_t;
  localparam logic [CNT_W-1:0] MAX = '1;
  state_t state;
  logic prev;
  logic [CNT_W-1:0] pcnt, hcnt;
  logic [10:0] exp_p;
  logic [3:0] good;
  logic rise, meas, changed, good_p, good_d, set_p, set_d, set_t;
  logic [10:0] exp_now;
  logic [3:0] good_inc;
  assign rise = i_div_clk & ~prev;
  assign meas = i_en && state == MEASURE && rise;
  assign exp_now = {1'b0, i_exp_div_num} + 11'd1;
  // a change of the expected divisor since the last rise voids the period just ended
  assign changed = exp_now != exp_p;
  assign good_p = 32'(pcnt) == 32'(exp_p);
  assign good_d = hcnt == (pcnt >> 1) || hcnt == pcnt - (pcnt >> 1);
  assign good_inc = good == 4'(LOCK_CNT) ? good : good + 4'd1;
  assign set_p = meas && !changed && !good_p;
  assign set_d = meas && !changed && good_p && !good_d;
  assign set_t = i_en && state == MEASURE && !rise && pcnt == MAX;
  always_ff @(posedge i_clk or negedge i_rst_b) begin
    if (!i_rst_b) begin
      state <= IDLE;
      prev <= 1'b0;
      pcnt <= '0;
      hcnt <= '0;
      exp_p <= '0;
      good <= '0;
      o_period <= '0;
      o_high_cnt <= '0;
      o_valid <= 1'b0;
      o_locked <= 1'b0;
      o_err_period <= 1'b0;
      o_err_duty <= 1'b0;
      o_err_timeout <= 1'b0;
    end else begin
      prev <= i_div_clk;
      o_valid <= 1'b0;
      o_err_period <= set_p | (o_err_period & ~i_err_clr);
      o_err_duty <= set_d | (o_err_duty & ~i_err_clr);
      o_err_timeout <= set_t | (o_err_timeout & ~i_err_clr);
      if (!i_en) begin
        state <= IDLE;
        good <= '0;
        o_locked <= 1'b0;
      end else if (state == IDLE) begin
        state <= ARM;
      end else if (rise) begin
        state <= MEASURE;
        pcnt <= CNT_W'(1);
        hcnt <= CNT_W'(1);
        exp_p <= exp_now;
        if (state == MEASURE) begin
          if (!changed) begin
            o_period <= pcnt;
            o_high_cnt <= hcnt;
            o_valid <= 1'b1;
          end
          good <= (!changed && good_p && good_d) ? good_inc : '0;
          o_locked <= !changed && good_p && good_d && good_inc == 4'(LOCK_CNT);
        end
      end else if (state == MEASURE) begin
        if (pcnt == MAX) begin
          state <= ARM;
          good <= '0;
          o_locked <= 1'b0;
        end else begin
          pcnt <= pcnt + CNT_W'(1);
          hcnt <= (i_div_clk && hcnt != MAX) ? hcnt + CNT_W'(1) : hcnt;
        end
      end
    end
  end
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: directed checks of period/duty measurement, lock, errors, timeout and reset.
module tb_clk_div_monitor;
  logic i_clk = 1'b0, i_rst_b = 1'b0, i_div_clk = 1'b0, i_en = 1'b0, i_err_clr = 1'b0;
  logic [9:0] i_exp_div_num = 10'd3;
  logic [10:0] o_period, o_high_cnt;
  logic o_valid, o_locked, o_err_period, o_err_duty, o_err_timeout;
  int passed = 0, total = 0;
  int nval, lk_at, lp, lh, k;
  clk_div_monitor dut (
    .i_clk(i_clk), .i_rst_b(i_rst_b), .i_div_clk(i_div_clk), .i_en(i_en),
    .i_exp_div_num(i_exp_div_num), .i_err_clr(i_err_clr), .o_period(o_period),
    .o_high_cnt(o_high_cnt), .o_valid(o_valid), .o_locked(o_locked),
    .o_err_period(o_err_period), .o_err_duty(o_err_duty), .o_err_timeout(o_err_timeout)
  );
  always #5 i_clk = ~i_clk;
  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask
  task automatic clr_stats();
    nval = 0;
    lk_at = 0;
  endtask
  task automatic cyc(input logic d);
    i_div_clk = d;
    @(posedge i_clk);
    #1;
    if (o_valid) begin
      nval++;
      lp = int'(o_period);
      lh = int'(o_high_cnt);
      if (o_locked && lk_at == 0) lk_at = nval;
    end
  endtask
  task automatic period(input int hi, input int lo);
    repeat (hi) cyc(1'b1);
    repeat (lo) cyc(1'b0);
  endtask
  task automatic err_clr_pulse(input logic d);
    i_err_clr = 1'b1;
    cyc(d);
    i_err_clr = 1'b0;
  endtask
  initial begin
    clr_stats();
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_period", int'(o_period), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_locked", int'(o_locked), 0);
    check("rst_errs", int'({o_err_period, o_err_duty, o_err_timeout}), 0);
    i_rst_b = 1'b1;
    i_en = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    // N=3, 2 high / 2 low
    clr_stats();
    repeat (6) period(2, 2);
    check("n3_nval", nval, 5);
    check("n3_lock_at", lk_at, 4);
    check("n3_period", lp, 4);
    check("n3_high", lh, 2);
    check("n3_errs", int'({o_err_period, o_err_duty, o_err_timeout}), 0);
    // N=4: changing N discards the next measurement
    i_exp_div_num = 10'd4;
    clr_stats();
    repeat (3) period(2, 3);
    check("n4_nval", nval, 2);
    check("n4_period", lp, 5);
    check("n4_high", lh, 2);
    check("n4_duty_ok", int'(o_err_duty), 0);
    repeat (2) period(1, 4);
    check("n4_bad_high", lh, 1);
    check("n4_err_duty", int'(o_err_duty), 1);
    check("n4_err_period", int'(o_err_period), 0);
    check("n4_lock_at", lk_at, 0);
    check("n4_locked", int'(o_locked), 0);
    err_clr_pulse(1'b0);
    check("duty_clr", int'(o_err_duty), 0);
    // relock at N=3, then one 5-cycle period
    i_exp_div_num = 10'd3;
    clr_stats();
    repeat (6) period(2, 2);
    check("relock_nval", nval, 5);
    check("relock_lock_at", lk_at, 4);
    check("relock_locked", int'(o_locked), 1);
    period(3, 2);
    period(2, 2);
    check("badp_err", int'(o_err_period), 1);
    check("badp_locked", int'(o_locked), 0);
    check("badp_period", lp, 5);
    check("badp_high", lh, 3);
    clr_stats();
    repeat (4) period(2, 2);
    check("relock2_nval", nval, 4);
    check("relock2_lock_at", lk_at, 4);
    check("err_sticky", int'(o_err_period), 1);
    err_clr_pulse(1'b0);
    check("period_clr", int'(o_err_period), 0);
    // timeout: one rise then stuck low
    clr_stats();
    cyc(1'b1);
    k = 0;
    while (!o_err_timeout && k < 2100) begin
      cyc(1'b0);
      k++;
    end
    check("to_cycles", k, 2047);
    check("to_err", int'(o_err_timeout), 1);
    check("to_nval", nval, 1);
    check("to_locked", int'(o_locked), 0);
    clr_stats();
    repeat (2) period(2, 2);
    check("to_rearm_nval", nval, 1);
    check("to_rearm_period", lp, 4);
    // N 3->5 mid-period
    err_clr_pulse(1'b1);
    cyc(1'b1);
    check("to_clr", int'({o_err_period, o_err_duty, o_err_timeout}), 0);
    i_exp_div_num = 10'd5;
    cyc(1'b0);
    cyc(1'b0);
    clr_stats();
    repeat (5) period(3, 3);
    check("n5_nval", nval, 4);
    check("n5_lock_at", lk_at, 4);
    check("n5_period", lp, 6);
    check("n5_high", lh, 3);
    check("n5_errs", int'({o_err_period, o_err_duty, o_err_timeout}), 0);
    // disable drops lock, holds measurement
    i_en = 1'b0;
    cyc(1'b0);
    check("dis_locked", int'(o_locked), 0);
    check("dis_period", int'(o_period), 6);
    cyc(1'b0);
    // locked with an error set, then async reset mid-period
    i_en = 1'b1;
    cyc(1'b0);
    period(2, 2);
    repeat (5) period(3, 3);
    check("pre_rst_locked", int'(o_locked), 1);
    check("pre_rst_err", int'(o_err_period), 1);
    cyc(1'b1);
    cyc(1'b1);
    #2;
    i_rst_b = 1'b0;
    #1;
    check("arst_locked", int'(o_locked), 0);
    check("arst_err", int'(o_err_period), 0);
    check("arst_period", int'(o_period), 0);
    check("arst_high", int'(o_high_cnt), 0);
    #1;
    i_rst_b = 1'b1;
    clr_stats();
    cyc(1'b0);
    cyc(1'b0);
    period(3, 3);
    check("post_rst_nval0", nval, 0);
    period(3, 3);
    check("post_rst_nval1", nval, 1);
    check("post_rst_period", lp, 6);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
